// File: rtl/theme_pkg.sv
// rtl/theme_pkg.sv - shared constants, colour ROM and channel helpers for the palette controller
package theme_pkg;

  localparam int IDX_W       = 4;
  localparam int MAX_THEMES  = 16;
  localparam int MAX_COLOURS = 8;

  // RGB565 channel layout
  localparam int R_OFF = 11;
  localparam int R_W   = 5;
  localparam int G_OFF = 5;
  localparam int G_W   = 6;
  localparam int B_OFF = 0;
  localparam int B_W   = 5;

  // Slot order per theme: background, low, medium, high, border, spare...
  localparam logic [15:0] THEME_ROM [MAX_THEMES][MAX_COLOURS] = '{
    '{16'h0000, 16'h07E0, 16'hFFE0, 16'hF800, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000},
    '{16'hFFE0, 16'h001F, 16'h07FF, 16'hF81F, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
    '{16'h3D19, 16'h31A6, 16'h632C, 16'hAD55, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
    '{16'hFFFF, 16'h0000, 16'h7BEF, 16'hF800, 16'h001F, 16'h0000, 16'h0000, 16'h0000},
    '{default: 16'h0000}, '{default: 16'h0000}, '{default: 16'h0000}, '{default: 16'h0000},
    '{default: 16'h0000}, '{default: 16'h0000}, '{default: 16'h0000}, '{default: 16'h0000},
    '{default: 16'h0000}, '{default: 16'h0000}, '{default: 16'h0000}, '{default: 16'h0000}
  };

  // Channel index 0 = red, 1 = green, 2 = blue
  function automatic int chan_off(input int ch);
    return (ch == 0) ? R_OFF : (ch == 1) ? G_OFF : B_OFF;
  endfunction

  function automatic int chan_w(input int ch);
    return (ch == 0) ? R_W : (ch == 1) ? G_W : B_W;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - pushbutton synchroniser, stability filter and single-shot press request
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic req
);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          pressed;
  logic          pressed_q;

  // Counter saturates at DEBOUNCE_CYCLES, so "pressed" holds for as long as the button does
  assign pressed = (cnt == CW'(DEBOUNCE_CYCLES));

  // Synchronise, count consecutive high samples, and emit one request per rising edge of pressed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync      <= '0;
      cnt       <= '0;
      pressed_q <= 1'b0;
      req       <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      if (!sync[1]) begin
        cnt <= '0;
      end else if (!pressed) begin
        cnt <= cnt + CW'(1);
      end
      pressed_q <= pressed;
      req       <= pressed & ~pressed_q;
    end
  end

endmodule

// File: rtl/rgb565_lerp.sv
// rtl/rgb565_lerp.sv - combinational per-channel linear blend of one RGB565 colour slot
module rgb565_lerp
  import theme_pkg::*;
#(
  parameter int FADE_STEPS = 16,
  localparam int SH = $clog2(FADE_STEPS),
  localparam int KW = SH + 1
) (
  input  logic [15:0]   s,
  input  logic [15:0]   t,
  input  logic [KW-1:0] k,
  output logic [15:0]   c
);

  // Intermediate holds +/-63 * FADE_STEPS plus sign; floor rounding keeps c between s and t
  localparam int IW = 8 + SH;

  for (genvar ch = 0; ch < 3; ch++) begin : g_chan
    localparam int OFF = chan_off(ch);
    localparam int W   = chan_w(ch);

    logic signed [IW-1:0] d;
    logic signed [IW-1:0] kk;
    logic        [W-1:0]  cc;

    // Blend one channel: s + ((t - s) * k) >>> log2(FADE_STEPS)
    always_comb begin
      d  = signed'(IW'(t[OFF +: W])) - signed'(IW'(s[OFF +: W]));
      kk = signed'(IW'(k));
      cc = W'(signed'(IW'(s[OFF +: W])) + ((d * kk) >>> SH));
    end

    assign c[OFF +: W] = cc;
  end

endmodule

// File: rtl/theme_palette_ctrl.sv
// rtl/theme_palette_ctrl.sv - theme selector with debounced buttons and crossfaded palette output
module theme_palette_ctrl
  import theme_pkg::*;
#(
  parameter int NUM_THEMES      = 4,
  parameter int NUM_COLOURS     = 5,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int FADE_STEPS      = 16,
  parameter int STEP_DIV        = 65536
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     btn_next,
  input  logic                     btn_prev,
  input  logic                     sel_valid,
  input  logic [3:0]               sel_idx,
  output logic [3:0]               theme_idx,
  output logic                     busy,
  output logic [NUM_COLOURS*16-1:0] palette
);

  localparam int PW = NUM_COLOURS * 16;
  localparam int KW = $clog2(FADE_STEPS) + 1;
  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  typedef enum logic {IDLE, FADE} state_t;

  function automatic logic [PW-1:0] rom_palette(input logic [IDX_W-1:0] idx);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < NUM_COLOURS; i++) begin
      p[16*i +: 16] = THEME_ROM[idx][i];
    end
    return p;
  endfunction

  state_t            state;
  logic [PW-1:0]     start_pal;
  logic [PW-1:0]     tgt_pal;
  logic [PW-1:0]     lerp_pal;
  logic [KW-1:0]     k;
  logic [KW-1:0]     k_next;
  logic [SW-1:0]     step_cnt;
  logic              next_req;
  logic              prev_req;
  logic              req_ok;
  logic [IDX_W-1:0]  target;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk(clk), .rst_n(rst_n), .btn(btn_next), .req(next_req)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
    .clk(clk), .rst_n(rst_n), .btn(btn_prev), .req(prev_req)
  );

  assign tgt_pal = rom_palette(theme_idx);
  assign k_next  = k + KW'(1);

  // Each slot always shows the blend for the step about to be taken
  for (genvar i = 0; i < NUM_COLOURS; i++) begin : g_slot
    rgb565_lerp #(.FADE_STEPS(FADE_STEPS)) u_lerp (
      .s(start_pal[16*i +: 16]),
      .t(tgt_pal[16*i +: 16]),
      .k(k_next),
      .c(lerp_pal[16*i +: 16])
    );
  end

  // Arbitrate: direct select wins, conflicting buttons cancel, no-op targets are dropped
  always_comb begin
    req_ok = 1'b0;
    target = theme_idx;
    if (sel_valid) begin
      if ({1'b0, sel_idx} < 5'(NUM_THEMES)) begin
        req_ok = 1'b1;
        target = sel_idx;
      end
    end else if (next_req ^ prev_req) begin
      req_ok = 1'b1;
      if (next_req) begin
        target = (theme_idx == IDX_W'(NUM_THEMES - 1)) ? '0 : theme_idx + IDX_W'(1);
      end else begin
        target = (theme_idx == '0) ? IDX_W'(NUM_THEMES - 1) : theme_idx - IDX_W'(1);
      end
    end
    if (target == theme_idx) begin
      req_ok = 1'b0;
    end
  end

  // Fade FSM: a new request (also mid-fade) restarts from whatever is on screen now
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      theme_idx <= '0;
      busy      <= 1'b0;
      palette   <= rom_palette('0);
      start_pal <= rom_palette('0);
      k         <= '0;
      step_cnt  <= '0;
    end else if (req_ok) begin
      theme_idx <= target;
      start_pal <= palette;
      k         <= '0;
      step_cnt  <= '0;
      busy      <= 1'b1;
      state     <= FADE;
    end else if (state == FADE) begin
      if (step_cnt == SW'(STEP_DIV - 1)) begin
        step_cnt <= '0;
        k        <= k_next;
        palette  <= lerp_pal;
        if (k_next == KW'(FADE_STEPS)) begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      end else begin
        step_cnt <= step_cnt + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_theme_palette_ctrl.sv
// tb/tb_theme_palette_ctrl.sv - scoreboard bench for theme_palette_ctrl
module tb_theme_palette_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_next;
  logic        btn_prev;
  logic        sel_valid;
  logic [3:0]  sel_idx;
  logic [3:0]  theme_idx;
  logic        busy;
  logic [79:0] palette;

  int passed = 0;
  int total  = 0;

  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];

  int          w_busy;
  int          w_starts;
  int          w_rise;
  logic [15:0] w_fall;
  int          clean_rise;

  theme_palette_ctrl #(
    .NUM_THEMES(4), .NUM_COLOURS(5), .DEBOUNCE_CYCLES(4), .FADE_STEPS(4), .STEP_DIV(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_next(btn_next), .btn_prev(btn_prev),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .theme_idx(theme_idx),
    .busy(busy), .palette(palette)
  );

  always #5 clk = ~clk;

  // Reference blend: floor((t - s) * k / 4) per channel, done with integer division
  function automatic logic [15:0] model(input logic [15:0] s, input logic [15:0] t, input int k);
    int sc[3];
    int tc[3];
    int oc[3];
    int d;
    int q;
    sc = '{int'(s[15:11]), int'(s[10:5]), int'(s[4:0])};
    tc = '{int'(t[15:11]), int'(t[10:5]), int'(t[4:0])};
    for (int ch = 0; ch < 3; ch++) begin
      d = (tc[ch] - sc[ch]) * k;
      q = d / 4;
      if (d < 0 && (d % 4) != 0) q = q - 1;
      oc[ch] = sc[ch] + q;
    end
    return {5'(oc[0]), 6'(oc[1]), 5'(oc[2])};
  endfunction

  task automatic push_fade(input logic [15:0] s, input logic [15:0] t);
    logic [15:0] last;
    logic [15:0] v;
    last = s;
    for (int k = 1; k <= 4; k++) begin
      v = model(s, t, k);
      if (v != last) exp_q.push_back(v);
      last = v;
    end
  endtask

  // Drive button patterns one bit per cycle and record slot0 changes and busy activity
  task automatic watch(input logic [63:0] pn, input logic [63:0] pp, input int budget);
    logic [15:0] last;
    logic        pb;
    last     = palette[15:0];
    pb       = busy;
    w_busy   = 0;
    w_starts = 0;
    w_rise   = -1;
    w_fall   = 16'hxxxx;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      sel_valid = 1'b0;
      btn_next  = (c < 64) ? pn[c] : 1'b0;
      btn_prev  = (c < 64) ? pp[c] : 1'b0;
      if (busy && !pb) begin
        w_starts++;
        if (w_rise < 0) w_rise = c;
      end
      if (!busy && pb) w_fall = palette[15:0];
      if (busy) w_busy++;
      if (palette[15:0] !== last) begin
        obs_q.push_back(palette[15:0]);
        last = palette[15:0];
      end
      pb = busy;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; btn_next = 1'b0; btn_prev = 1'b0; sel_valid = 1'b0; sel_idx = 4'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (theme_idx !== 4'd0) $display("FAIL reset_theme got %h want 0", theme_idx); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (palette[15:0] !== 16'h0000) $display("FAIL reset_slot0 got %h want 0000", palette[15:0]); else passed++;
    total++; if (palette[79:64] !== 16'hFFFF) $display("FAIL reset_slot4 got %h want FFFF", palette[79:64]); else passed++;
  endtask

  task automatic test_single_press;
    logic [15:0] e;
    logic [15:0] o;
    exp_q.push_back(16'h39E0); exp_q.push_back(16'h7BE0);
    exp_q.push_back(16'hBDE0); exp_q.push_back(16'hFFE0);
    watch(64'h3FF, 64'h0, 30);
    clean_rise = w_rise;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
      total++; if (o !== e) $display("FAIL press_slot0 got %h want %h", o, e); else passed++;
    end
    total++; if (obs_q.size() != 0) $display("FAIL press_extra got %0d want 0", obs_q.size()); else passed++;
    obs_q.delete();
    total++; if (w_starts != 1) $display("FAIL press_starts got %0d want 1", w_starts); else passed++;
    total++; if (w_busy != 8) $display("FAIL press_busy_len got %0d want 8", w_busy); else passed++;
    total++; if (w_fall !== 16'hFFE0) $display("FAIL press_fall_slot0 got %h want FFE0", w_fall); else passed++;
    total++; if (theme_idx !== 4'd1) $display("FAIL press_theme got %h want 1", theme_idx); else passed++;
    total++; if (palette[79:64] !== 16'h0000) $display("FAIL press_slot4 got %h want 0000", palette[79:64]); else passed++;
  endtask

  task automatic test_bounce;
    logic [15:0] e;
    logic [15:0] o;
    push_fade(16'hFFE0, 16'h3D19);
    watch(64'h3FF5, 64'h0, 34);
    total++; if (w_rise != clean_rise + 4) $display("FAIL bounce_rise got %0d want %0d", w_rise, clean_rise + 4); else passed++;
    total++; if (w_starts != 1) $display("FAIL bounce_starts got %0d want 1", w_starts); else passed++;
    total++; if (theme_idx !== 4'd2) $display("FAIL bounce_theme got %h want 2", theme_idx); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
      total++; if (o !== e) $display("FAIL bounce_slot0 got %h want %h", o, e); else passed++;
    end
    total++; if (obs_q.size() != 0) $display("FAIL bounce_extra got %0d want 0", obs_q.size()); else passed++;
    obs_q.delete();
  endtask

  task automatic test_select_wrap;
    logic [15:0] e;
    logic [15:0] o;
    push_fade(16'h3D19, 16'hFFFF);
    @(negedge clk); sel_valid = 1'b1; sel_idx = 4'd3;
    watch(64'h0, 64'h0, 20);
    total++; if (theme_idx !== 4'd3) $display("FAIL sel_theme got %h want 3", theme_idx); else passed++;
    push_fade(16'hFFFF, 16'h0000);
    watch(64'h3FF, 64'h0, 30);
    total++; if (theme_idx !== 4'd0) $display("FAIL wrap_next got %h want 0", theme_idx); else passed++;
    push_fade(16'h0000, 16'hFFFF);
    watch(64'h0, 64'h3FF, 30);
    total++; if (theme_idx !== 4'd3) $display("FAIL wrap_prev got %h want 3", theme_idx); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
      total++; if (o !== e) $display("FAIL selwrap_slot0 got %h want %h", o, e); else passed++;
    end
    total++; if (obs_q.size() != 0) $display("FAIL selwrap_extra got %0d want 0", obs_q.size()); else passed++;
    obs_q.delete();
  endtask

  task automatic test_retarget;
    logic [15:0] e;
    logic [15:0] o;
    bit hit;
    @(negedge clk); sel_valid = 1'b1; sel_idx = 4'd0;
    watch(64'h0, 64'h0, 20);
    obs_q.delete();
    @(negedge clk); sel_valid = 1'b1; sel_idx = 4'd1;
    @(negedge clk); sel_valid = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (palette[15:0] === 16'h7BE0) hit = 1'b1;
    end
    total++; if (!hit) $display("FAIL retarget_reach_7BE0 got %h want 7BE0 within 20 cycles", palette[15:0]); else passed++;
    sel_valid = 1'b1; sel_idx = 4'd2;
    @(negedge clk); sel_valid = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL retarget_busy got %b want 1", busy); else passed++;
    total++; if (theme_idx !== 4'd2) $display("FAIL retarget_theme got %h want 2", theme_idx); else passed++;
    total++; if (palette[15:0] !== 16'h7BE0) $display("FAIL retarget_nojump got %h want 7BE0", palette[15:0]); else passed++;
    push_fade(16'h7BE0, 16'h3D19);
    watch(64'h0, 64'h0, 20);
    total++; if (1 + w_busy != 8) $display("FAIL retarget_busy_len got %0d want 8", 1 + w_busy); else passed++;
    total++; if (w_fall !== 16'h3D19) $display("FAIL retarget_final got %h want 3D19", w_fall); else passed++;
    total++; if (w_starts != 0) $display("FAIL retarget_restarts got %0d want 0", w_starts); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
      total++; if (o !== e) $display("FAIL retarget_slot0 got %h want %h", o, e); else passed++;
    end
    total++; if (obs_q.size() != 0) $display("FAIL retarget_extra got %0d want 0", obs_q.size()); else passed++;
    obs_q.delete();
    @(negedge clk); sel_valid = 1'b1; sel_idx = 4'd9;
    watch(64'h0, 64'h0, 10);
    total++; if (w_starts != 0) $display("FAIL badsel_starts got %0d want 0", w_starts); else passed++;
    total++; if (theme_idx !== 4'd2) $display("FAIL badsel_theme got %h want 2", theme_idx); else passed++;
    total++; if (obs_q.size() != 0) $display("FAIL badsel_changes got %0d want 0", obs_q.size()); else passed++;
    obs_q.delete();
  endtask

  task automatic test_reset_mid_fade_and_both;
    @(negedge clk); sel_valid = 1'b1; sel_idx = 4'd1;
    watch(64'h0, 64'h0, 3);
    #2 rst_n = 1'b0;
    #1;
    total++; if (palette[15:0] !== 16'h0000) $display("FAIL async_rst_slot0 got %h want 0000", palette[15:0]); else passed++;
    total++; if (palette[79:64] !== 16'hFFFF) $display("FAIL async_rst_slot4 got %h want FFFF", palette[79:64]); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL async_rst_busy got %b want 0", busy); else passed++;
    total++; if (theme_idx !== 4'd0) $display("FAIL async_rst_theme got %h want 0", theme_idx); else passed++;
    @(negedge clk); rst_n = 1'b1;
    obs_q.delete();
    watch(64'h3FF, 64'h3FF, 30);
    total++; if (w_starts != 0) $display("FAIL both_starts got %0d want 0", w_starts); else passed++;
    total++; if (theme_idx !== 4'd0) $display("FAIL both_theme got %h want 0", theme_idx); else passed++;
    total++; if (obs_q.size() != 0) $display("FAIL both_changes got %0d want 0", obs_q.size()); else passed++;
    obs_q.delete();
  endtask

  initial begin
    test_reset;
    test_single_press;
    test_bounce;
    test_select_wrap;
    test_retarget;
    test_reset_mid_fade_and_both;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/theme_palette_ctrl.md
Name: theme_palette_ctrl

Overview:
- Parametrised successor to the single-button three-theme selector.
- Holds NUM_THEMES palettes of NUM_COLOURS RGB565 colour slots (background, low, medium, high, border, ...).
- Theme change sources: debounced next/prev buttons, or a direct-select strobe.
- Crossfades the displayed palette linearly to the new theme instead of switching instantly. Sits between the pushbutton pins and the OLED/VGA pixel-colour logic.

Parameters:
- NUM_THEMES, 4, number of stored themes (2..16).
- NUM_COLOURS, 5, colour slots per theme.
- DEBOUNCE_CYCLES, 250000, cycles a synchronised button must be stable high before it counts as pressed.
- FADE_STEPS, 16, interpolation steps per transition; power of two, 1..64.
- STEP_DIV, 65536, clk cycles per interpolation step; at least 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- btn_next  in  1  raw asynchronous pushbutton; advance theme.
- btn_prev  in  1  raw asynchronous pushbutton; previous theme.
- sel_valid  in  1  one-cycle strobe; jump to sel_idx.
- sel_idx  in  4  target theme for sel_valid.
- theme_idx  out  4  current target theme.
- busy  out  1  high while a fade is in progress.
- palette  out  NUM_COLOURS*16  displayed colours; slot i occupies bits [16i+15:16i].
- Interface decision: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset values: theme_idx=0, busy=0, palette=theme 0 colours, debounce counters=0, FSM=IDLE.
- Reset is honoured mid-fade; no partial state survives it.
- Button input path:
  - 2-flop synchroniser.
  - Stability counter: "pressed" asserts once the synchronised level has been high for DEBOUNCE_CYCLES consecutive cycles; any low sample clears the counter.
  - A registered rising edge of "pressed" produces a one-cycle request.
  - One press gives exactly one request, however long it is held.
- Request arbitration, evaluated each cycle:
  - sel_valid has priority over button requests.
  - sel_valid with sel_idx >= NUM_THEMES is ignored.
  - Next and prev requests in the same cycle with no sel_valid: both ignored.
  - A request whose target equals theme_idx is ignored and busy stays unchanged.
- Wrap-around: next from NUM_THEMES-1 goes to 0; prev from 0 goes to NUM_THEMES-1.
- FSM state IDLE:
  - On an accepted request, next cycle: theme_idx<=target, start palette<=current palette, k<=0, step counter<=0, busy<=1, move to FADE.
- FSM state FADE:
  - Step counter counts 0..STEP_DIV-1. On wrap, k<=k+1 and the palette register loads lerp(start, target, k+1).
  - When k reaches FADE_STEPS the palette equals the target exactly. In that same cycle busy<=0 and the FSM returns to IDLE.
  - Fade duration is FADE_STEPS*STEP_DIV cycles after busy rises.
- Retarget: an accepted request during FADE captures the currently displayed palette as the new start and loads the new target; k and the step counter clear and busy stays 1. Colours never jump.
- Interpolation, per channel (R5, G6, B5):
  - c = s + (((t - s) * k) >>> log2(FADE_STEPS)).
  - Signed intermediate, 8 + log2(FADE_STEPS) bits; arithmetic shift, floor rounding.
  - Result always stays within [min(s,t), max(s,t)].
- palette is fully registered; no combinational path from any input to any output.

Decomposition:
- Package theme_pkg holds:
  - RGB565 field offsets and widths.
  - THEME_ROM constant array [16][8] of 16-bit colours. Entries used with the default parameters: theme 0 = {0000, 07E0, FFE0, F800, FFFF}; theme 1 = {FFE0, 001F, 07FF, F81F, 0000}; theme 2 = {3D19, 31A6, 632C, AD55, 0000}; theme 3 = {FFFF, 0000, 7BEF, F800, 001F}.
  - Theme-index width constant (4).
- Sub-modules:
  - rgb565_lerp: combinational, one slot, inputs s, t, k; instantiated NUM_COLOURS times.
  - btn_debounce: synchroniser, stability counter and edge detector; instantiated twice.

Test Plan (DEBOUNCE_CYCLES=4, FADE_STEPS=4, STEP_DIV=2):
- Reset release, then idle 20 cycles -> theme_idx=0, busy=0, palette slot0=0000, slot4=FFFF.
- btn_next held high 10 cycles -> exactly one request; busy high for 8 cycles. Slot0 steps 0000 -> 39E0 -> 7BE0 -> BDE0 -> FFE0. theme_idx=1; busy falls the cycle slot0=FFE0.
- btn_next bouncing 1,0,1,0 each cycle, then stable -> no request until 4 stable-high cycles; exactly one theme advance.
- sel_idx=3 with sel_valid -> theme_idx=3. Then btn_next pressed -> theme_idx wraps to 0. From theme_idx=0, btn_prev pressed -> theme_idx=3.
- Theme 0 -> 1 fade; at k=2 (slot0=7BE0), sel_valid with sel_idx=2 -> new start 7BE0, target 3D19, busy stays 1, final slot0=3D19 after 8 more cycles. sel_idx=9 -> ignored.
- rst_n pulled low mid-fade -> palette is theme 0 immediately (asynchronous), busy=0; both buttons pressed in the same cycle -> no change.
